// File: rtl/regfile_sb_pkg.sv
// Shared definitions for the scoreboarded register file: default geometry,
// the hard-wired zero register address and packed-bus slicing.
package regfile_sb_pkg;

   localparam int DEF_DATA_W  = 32;
   localparam int DEF_ADDR_W  = 5;
   localparam int DEF_NUM_RD  = 2;
   localparam int DEF_CNT_W   = 2;

   localparam int ZERO_ADDR   = 0;

   // Widest packed bus / slice the helper can handle; callers widen and truncate.
   localparam int BUS_MAX_W   = 1024;
   localparam int SLICE_MAX_W = 64;

   function automatic logic [SLICE_MAX_W-1:0] port_slice(input logic [BUS_MAX_W-1:0] bus,
                                                         input int k,
                                                         input int w);
      logic [BUS_MAX_W-1:0] sh;
      sh = bus >> (k * w);
      return sh[SLICE_MAX_W-1:0];
   endfunction

endpackage

// File: rtl/regfile_sb_counter.sv
// Saturating up/down pending-write counter for one register.
// Increments are refused at the maximum unless a decrement lands in the same cycle.
module sb_counter #(
   parameter int CNT_W = 2
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             zero,
   output logic             err
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic eff_inc;
   logic eff_dec;

   assign full    = (count == CNT_MAX);
   assign zero    = (count == '0);
   assign eff_dec = dec & ~zero;
   assign eff_inc = inc & (~full | eff_dec);
   // Underflowing retirement or refused allocation.
   assign err     = (dec & zero) | (inc & ~eff_inc);

   always_ff @(posedge CLK) begin
      if (Reset) begin
         count <= '0;
      end else if (eff_inc && !eff_dec) begin
         count <= count + CNT_W'(1);
      end else if (eff_dec && !eff_inc) begin
         count <= count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// General register file with write-through bypass and per-register
// pending-write scoreboard used by decode-stage stall logic.
module regfile_sb
   import regfile_sb_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_RD   = DEF_NUM_RD,
   parameter int CNT_W    = DEF_CNT_W,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic                     CLK,
   input  logic                     Reset,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     issue_valid,
   input  logic [ADDR_W-1:0]        issue_addr,
   output logic                     issue_ready,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   output logic                     sb_err
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_ADDR);

   logic [DATA_W-1:0]            mem [DEPTH];
   logic [DEPTH-1:0][CNT_W-1:0]  cnt;
   logic [DEPTH-1:0]             full_v;
   logic [DEPTH-1:0]             zero_v;
   logic [DEPTH-1:0]             err_v;
   logic [BUS_MAX_W-1:0]         rd_addr_ext;

   logic wr_zero;
   logic is_zero;
   logic is_retire_same;

   assign wr_zero        = ZERO_REG && (wr_addr == ZADDR);
   assign is_zero        = ZERO_REG && (issue_addr == ZADDR);
   assign is_retire_same = wr_en && (wr_addr == issue_addr);
   assign rd_addr_ext    = BUS_MAX_W'(rd_addr);

   // A full register can still accept an allocation when it retires this cycle.
   assign issue_ready = is_zero || !(full_v[issue_addr] && !is_retire_same);

   // One counter per register; register 0 is never fed when hard-wired.
   for (genvar r = 0; r < DEPTH; r++) begin : g_cnt
      localparam bit IS_Z = ZERO_REG && (r == ZERO_ADDR);
      logic inc_r;
      logic dec_r;

      assign inc_r = !IS_Z && issue_valid && (issue_addr == ADDR_W'(r));
      assign dec_r = !IS_Z && wr_en && (wr_addr == ADDR_W'(r));

      sb_counter #(.CNT_W(CNT_W)) u_cnt (
         .CLK   (CLK),
         .Reset (Reset),
         .inc   (inc_r),
         .dec   (dec_r),
         .count (cnt[r]),
         .full  (full_v[r]),
         .zero  (zero_v[r]),
         .err   (err_v[r])
      );
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en && !wr_zero) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         sb_err <= 1'b0;
      end else if (|err_v) begin
         sb_err <= 1'b1;
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rdv;
      logic              busy;
      logic              ra_zero;
      logic              ra_wr_hit;

      assign ra        = ADDR_W'(port_slice(rd_addr_ext, k, ADDR_W));
      assign ra_zero   = ZERO_REG && (ra == ZADDR);
      assign ra_wr_hit = wr_en && (wr_addr == ra);

      always_comb begin
         rdv = mem[ra];
         if (ra_zero) begin
            rdv = '0;
         end else if (ra_wr_hit) begin
            rdv = wr_data;
         end
      end

      // Busy reflects the count after this cycle's retirement, if any.
      always_comb begin
         busy = (cnt[ra] != '0);
         if (ra_wr_hit && (cnt[ra] == CNT_W'(1))) begin
            busy = 1'b0;
         end
         if (ra_zero) begin
            busy = 1'b0;
         end
      end

      assign rd_data[k*DATA_W +: DATA_W] = rdv;
      assign rd_busy[k]                  = busy;
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: per-cycle vectors with expected combinational outputs,
// queued when driven and compared mid-cycle before the next rising edge.
module tb_regfile_sb;

   logic        CLK = 1'b0;
   logic        Reset;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic [1:0]  rd_busy;
   logic        issue_valid;
   logic [4:0]  issue_addr;
   logic        issue_ready;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        sb_err;

   regfile_sb dut (
      .CLK         (CLK),
      .Reset       (Reset),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .rd_busy     (rd_busy),
      .issue_valid (issue_valid),
      .issue_addr  (issue_addr),
      .issue_ready (issue_ready),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .sb_err      (sb_err)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int          id;
      logic        rst;
      logic        chk;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        iv;
      logic [4:0]  ia;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [31:0] e0;
      logic [31:0] e1;
      logic [1:0]  eb;
      logic        erdy;
      logic        eerr;
   } vec_t;

   vec_t exp_q[$];
   vec_t tbl[$];
   int   total = 0;
   int   bad   = 0;
   int   next_id = 0;

   function automatic vec_t mk(logic rst, logic chk, logic we, logic [4:0] wa, logic [31:0] wd,
                               logic iv, logic [4:0] ia, logic [4:0] ra0, logic [4:0] ra1,
                               logic [31:0] e0, logic [31:0] e1, logic [1:0] eb,
                               logic erdy, logic eerr);
      vec_t v;
      v.id = 0; v.rst = rst; v.chk = chk; v.we = we; v.wa = wa; v.wd = wd;
      v.iv = iv; v.ia = ia; v.ra0 = ra0; v.ra1 = ra1; v.e0 = e0; v.e1 = e1;
      v.eb = eb; v.erdy = erdy; v.eerr = eerr;
      return v;
   endfunction

   task automatic cmp(input int id, input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL step %0d %s: got %h expected %h", id, nm, act, req);
      end
   endtask

   task automatic check_out();
      vec_t e;
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard: queue empty, got 0 expected 1 entries");
      end else begin
         e = exp_q.pop_front();
         cmp(e.id, "rd_data0", rd_data[31:0], e.e0);
         cmp(e.id, "rd_data1", rd_data[63:32], e.e1);
         cmp(e.id, "rd_busy", 32'(rd_busy), 32'(e.eb));
         cmp(e.id, "issue_ready", 32'(issue_ready), 32'(e.erdy));
         cmp(e.id, "sb_err", 32'(sb_err), 32'(e.eerr));
      end
   endtask

   task automatic apply(input vec_t v);
      @(negedge CLK);
      v.id        = next_id;
      next_id++;
      Reset       = v.rst;
      wr_en       = v.we;
      wr_addr     = v.wa;
      wr_data     = v.wd;
      issue_valid = v.iv;
      issue_addr  = v.ia;
      rd_addr     = {v.ra1, v.ra0};
      if (v.chk) exp_q.push_back(v);
      #2;
      if (v.chk) check_out();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      issue_valid = 1'b0; issue_addr = '0; rd_addr = '0;

      // Power-on reset and reset state
      apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0));
      apply(mk(0, 1, 0, 0, 0, 0, 0, 5, 0, 0, 0, 2'b00, 1, 0));

      // Preload r5 (unallocated write raises sb_err), then reset clears everything;
      // writes/issues presented during the reset cycle must be ignored.
      apply(mk(0, 1, 1, 5, 32'h1234, 0, 0, 5, 0, 32'h1234, 0, 2'b00, 1, 0));
      apply(mk(0, 1, 0, 0, 0, 0, 0, 5, 0, 32'h1234, 0, 2'b00, 1, 1));
      apply(mk(1, 0, 1, 6, 32'hAAAA, 1, 6, 0, 0, 0, 0, 2'b00, 1, 0));
      apply(mk(0, 1, 0, 0, 0, 0, 6, 5, 6, 0, 0, 2'b00, 1, 0));

      //               rst chk we wa wd            iv ia ra0 ra1 e0            e1            eb     rdy err
      tbl.push_back(mk(0, 1, 0, 0, 0,            1, 7, 7, 3, 0,            0,            2'b00, 1, 0));
      tbl.push_back(mk(0, 1, 1, 7, 32'hDEADBEEF, 1, 3, 7, 3, 32'hDEADBEEF, 0,            2'b00, 1, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0,            1, 3, 7, 3, 32'hDEADBEEF, 0,            2'b10, 1, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0,            1, 3, 7, 3, 32'hDEADBEEF, 0,            2'b10, 1, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0,            0, 3, 3, 7, 0,            32'hDEADBEEF, 2'b01, 0, 0));
      tbl.push_back(mk(0, 1, 1, 3, 32'h33,       0, 3, 3, 0, 32'h33,       0,            2'b01, 1, 0));
      tbl.push_back(mk(0, 1, 1, 3, 32'h44,       0, 3, 3, 3, 32'h44,       32'h44,       2'b11, 1, 0));
      tbl.push_back(mk(0, 1, 1, 3, 32'h55,       0, 3, 3, 3, 32'h55,       32'h55,       2'b00, 1, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0,            0, 3, 3, 7, 32'h55,       32'hDEADBEEF, 2'b00, 1, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0,            1, 4, 4, 3, 0,            32'h55,       2'b00, 1, 0));
      tbl.push_back(mk(0, 1, 1, 4, 32'h4444,     1, 4, 4, 5, 32'h4444,     0,            2'b00, 1, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0,            0, 4, 4, 4, 32'h4444,     32'h4444,     2'b11, 1, 0));
      tbl.push_back(mk(0, 1, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 4, 0,            32'h4444,     2'b10, 1, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0,            0, 0, 0, 0, 0,            0,            2'b00, 1, 0));
      tbl.push_back(mk(0, 1, 1, 4, 32'h1,        0, 4, 4, 0, 32'h1,        0,            2'b00, 1, 0));
      tbl.push_back(mk(0, 1, 1, 9, 32'h99,       0, 9, 9, 3, 32'h99,       32'h55,       2'b00, 1, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0,            0, 9, 9, 0, 32'h99,       0,            2'b00, 1, 1));
      tbl.push_back(mk(0, 1, 0, 0, 0,            1, 3, 3, 0, 32'h55,       0,            2'b00, 1, 1));
      tbl.push_back(mk(0, 1, 0, 0, 0,            1, 3, 3, 0, 32'h55,       0,            2'b01, 1, 1));
      tbl.push_back(mk(0, 1, 0, 0, 0,            1, 3, 3, 0, 32'h55,       0,            2'b01, 1, 1));
      tbl.push_back(mk(0, 1, 0, 0, 0,            1, 3, 3, 0, 32'h55,       0,            2'b01, 0, 1));
      tbl.push_back(mk(0, 1, 0, 0, 0,            0, 3, 3, 0, 32'h55,       0,            2'b01, 0, 1));
      tbl.push_back(mk(0, 1, 1, 3, 32'h1,        0, 3, 3, 0, 32'h1,        0,            2'b01, 1, 1));
      tbl.push_back(mk(0, 1, 1, 3, 32'h2,        0, 3, 3, 0, 32'h2,        0,            2'b01, 1, 1));
      tbl.push_back(mk(0, 1, 1, 3, 32'h3,        0, 3, 3, 0, 32'h3,        0,            2'b00, 1, 1));
      tbl.push_back(mk(0, 1, 0, 0, 0,            0, 3, 3, 9, 32'h3,        32'h99,       2'b00, 1, 1));

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i]);
      end

      // Reset with an allocation in flight discards it and clears the error.
      apply(mk(0, 1, 0, 0, 0, 1, 2, 2, 0, 0, 0, 2'b00, 1, 1));
      apply(mk(0, 1, 0, 0, 0, 0, 2, 2, 0, 0, 0, 2'b01, 1, 1));
      apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0));
      apply(mk(0, 1, 0, 0, 0, 0, 2, 2, 9, 0, 0, 2'b00, 1, 0));
      apply(mk(0, 1, 0, 0, 0, 0, 3, 7, 3, 0, 0, 2'b00, 1, 0));

      @(negedge CLK);
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard drain: got %0d expected 0 entries left", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
